// File: rtl/spi_input_conditioner.sv
// -----------------------------------------------------------------------------
// spi_input_conditioner
//
// Purpose:
//   Brings the raw, asynchronous SPI pins (sck, cs, mosi) into the clk domain.
//   Each pin goes through the same chain: a two-flop synchronizer, a debounce
//   counter and a conditioned level register. The block also produces
//   registered single-cycle edge strobes. Downstream logic (the SPI FSM and
//   the input shift register) uses these levels and strobes. It never samples
//   the pins or keeps its own copy of the previous sck value.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   sck_pin    in   raw SPI clock pin
//   cs_pin     in   raw chip select pin (active low)
//   mosi_pin   in   raw master-out data pin
//   sck_cond   out  conditioned SCK level (never gated)
//   cs_cond    out  conditioned CS level (1 = deselected)
//   mosi_cond  out  conditioned MOSI level
//   sck_rise   out  strobe: accepted SCK 0->1 while selected
//   sck_fall   out  strobe: accepted SCK 1->0 while selected
//   cs_fall    out  strobe: frame start (accepted CS 1->0)
//   cs_rise    out  strobe: frame end (accepted CS 0->1)
//
// Handshake: there is none. Every output is valid on every cycle after reset
// release. The strobes are valid-only pulses: each lasts exactly one cycle
// and has no ready or back-pressure path.
// -----------------------------------------------------------------------------
module spi_input_conditioner #(
   parameter int WAIT_CYCLES   = 3,
   parameter int COUNTER_WIDTH = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sck_pin,
   input  logic cs_pin,
   input  logic mosi_pin,
   output logic sck_cond,
   output logic cs_cond,
   output logic mosi_cond,
   output logic sck_rise,
   output logic sck_fall,
   output logic cs_fall,
   output logic cs_rise
);

   // Channel index within the packed per-channel vectors
   localparam int CH_SCK  = 0;
   localparam int CH_CS   = 1;
   localparam int CH_MOSI = 2;

   // CS idles high (deselected); SCK and MOSI idle low
   localparam logic [2:0] RST_LEVEL = 3'b010;

   // Terminal count: the change is accepted on the cycle in which the counter
   // already holds WAIT_CYCLES-1, so s1 must differ for WAIT_CYCLES edges.
   localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = COUNTER_WIDTH'(WAIT_CYCLES - 1);

   logic [2:0]               w_pin;
   logic [2:0]               r_s0;
   logic [2:0]               r_s1;
   logic [2:0]               r_cond;
   logic [COUNTER_WIDTH-1:0] r_cnt [3];
   logic [2:0]               w_accept;
   logic [2:0]               w_cond_next;

   logic r_sck_rise;
   logic r_sck_fall;
   logic r_cs_fall;
   logic r_cs_rise;

   assign w_pin = {mosi_pin, cs_pin, sck_pin};

   // Acceptance decision and the value each cond register takes on this edge.
   // The SCK strobe gate needs the CS level after this edge, so it uses
   // w_cond_next instead of r_cond. That lets a coincident cs_fall pass the
   // sck strobe and makes a coincident cs_rise block it.
   always_comb begin
      w_accept    = '0;
      w_cond_next = r_cond;
      for (int i = 0; i < 3; i++) begin
         w_accept[i]    = (r_s1[i] != r_cond[i]) && (r_cnt[i] == CNT_MAX);
         w_cond_next[i] = w_accept[i] ? r_s1[i] : r_cond[i];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s0       <= RST_LEVEL;
         r_s1       <= RST_LEVEL;
         r_cond     <= RST_LEVEL;
         for (int i = 0; i < 3; i++) begin
            r_cnt[i] <= '0;
         end
         r_sck_rise <= 1'b0;
         r_sck_fall <= 1'b0;
         r_cs_fall  <= 1'b0;
         r_cs_rise  <= 1'b0;
      end else begin
         r_s0   <= w_pin;
         r_s1   <= r_s0;
         r_cond <= w_cond_next;

         // Counter clears when the input matches again (glitch rejected) or
         // when the change is accepted. It therefore never passes CNT_MAX.
         for (int i = 0; i < 3; i++) begin
            if ((r_s1[i] == r_cond[i]) || w_accept[i]) begin
               r_cnt[i] <= '0;
            end else begin
               r_cnt[i] <= r_cnt[i] + 1'b1;
            end
         end

         r_sck_rise <= w_accept[CH_SCK] &  r_s1[CH_SCK] & ~w_cond_next[CH_CS];
         r_sck_fall <= w_accept[CH_SCK] & ~r_s1[CH_SCK] & ~w_cond_next[CH_CS];
         r_cs_fall  <= w_accept[CH_CS]  & ~r_s1[CH_CS];
         r_cs_rise  <= w_accept[CH_CS]  &  r_s1[CH_CS];
      end
   end

   assign sck_cond  = r_cond[CH_SCK];
   assign cs_cond   = r_cond[CH_CS];
   assign mosi_cond = r_cond[CH_MOSI];
   assign sck_rise  = r_sck_rise;
   assign sck_fall  = r_sck_fall;
   assign cs_fall   = r_cs_fall;
   assign cs_rise   = r_cs_rise;

endmodule

// File: tb/tb_spi_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_spi_input_conditioner
//
// Purpose:
//   Directed bench for spi_input_conditioner (WAIT_CYCLES = 3).
//   Stimulus drives the pins on the falling clock edge. For every strobe
//   pattern it expects, it pushes an entry into exp_q. Each entry holds the
//   negedge cycle on which the strobe should be seen, the 4-bit strobe vector
//   and the 3-bit conditioned levels. A separate monitor runs on every
//   negedge. Whenever any strobe is high it pops one entry and compares the
//   whole entry. Level-only checks (reset values, glitch rejection, gated
//   SCK) are made directly by the stimulus process.
//
// Entry layout: {cycle[15:0], {sck_rise,sck_fall,cs_fall,cs_rise},
//                {sck_cond,cs_cond,mosi_cond}}
// -----------------------------------------------------------------------------
module tb_spi_input_conditioner;

   localparam int W   = 23;
   localparam int LAT = 5;   // pin change before edge 1 -> strobe after edge 5

   logic clk;
   logic rst_n;
   logic sck_pin;
   logic cs_pin;
   logic mosi_pin;
   logic sck_cond;
   logic cs_cond;
   logic mosi_cond;
   logic sck_rise;
   logic sck_fall;
   logic cs_fall;
   logic cs_rise;

   logic [W-1:0] exp_q[$];
   int           cyc;
   int           n_cmp;
   int           n_mis;

   spi_input_conditioner #(
      .WAIT_CYCLES  (3),
      .COUNTER_WIDTH(3)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sck_pin  (sck_pin),
      .cs_pin   (cs_pin),
      .mosi_pin (mosi_pin),
      .sck_cond (sck_cond),
      .cs_cond  (cs_cond),
      .mosi_cond(mosi_cond),
      .sck_rise (sck_rise),
      .sck_fall (sck_fall),
      .cs_fall  (cs_fall),
      .cs_rise  (cs_rise)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- driver tasks ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called right after a pin change on a negedge
   task automatic expect_strobe(input logic [3:0] strb, input logic [2:0] conds);
      logic [15:0] c;
      c = 16'(cyc + LAT);
      exp_q.push_back({c, strb, conds});
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      n_cmp++;
      if (act !== req) begin
         n_mis++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [7:0] all_outs();
      return {1'b0, sck_cond, cs_cond, mosi_cond, sck_rise, sck_fall, cs_fall, cs_rise};
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [3:0]   strb;
      logic [W-1:0] act;
      logic [W-1:0] req;
      strb = {sck_rise, sck_fall, cs_fall, cs_rise};
      if (strb != 4'b0000) begin
         act = {16'(cyc), strb, sck_cond, cs_cond, mosi_cond};
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_mis++;
            $display("FAIL unexpected_strobe: got %0h, required no strobe", act);
         end else begin
            req = exp_q.pop_front();
            if (act !== req) begin
               n_mis++;
               $display("FAIL strobe_entry: got cyc=%0d strb=%b cond=%b, required cyc=%0d strb=%b cond=%b",
                        act[22:7], act[6:3], act[2:0], req[22:7], req[6:3], req[2:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] byte_val;

   initial begin
      n_cmp    = 0;
      n_mis    = 0;
      rst_n    = 1'b0;
      sck_pin  = 1'b0;
      cs_pin   = 1'b1;
      mosi_pin = 1'b0;
      byte_val = 8'hA5;

      // Reset state: sck=0, cs=1, mosi=0, no strobes
      tick(3);
      chk("reset_outs", all_outs(), 8'b0010_0000);
      rst_n = 1'b1;
      tick(6);
      chk("idle_outs", all_outs(), 8'b0010_0000);

      // Latency: CS 1->0, cs_fall after edge 5, gone after edge 6
      cs_pin = 1'b0;
      expect_strobe(4'b0010, 3'b000);
      tick(4);
      chk("cs_cond_before_edge5", {7'd0, cs_cond}, 8'd1);
      tick(1);
      chk("cs_cond_after_edge5", {7'd0, cs_cond}, 8'd0);
      tick(1);
      chk("cs_fall_after_edge6", {7'd0, cs_fall}, 8'd0);
      tick(4);

      // Glitch: MOSI high for 2 cycles -> rejected
      mosi_pin = 1'b1;
      tick(2);
      mosi_pin = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         chk("mosi_glitch_rejected", {7'd0, mosi_cond}, 8'd0);
      end

      // 3-cycle pulse -> accepted on the 5th edge, drops back later
      mosi_pin = 1'b1;
      tick(3);
      mosi_pin = 1'b0;
      tick(1);
      chk("mosi_pulse_edge4", {7'd0, mosi_cond}, 8'd0);
      tick(1);
      chk("mosi_pulse_edge5", {7'd0, mosi_cond}, 8'd1);
      tick(5);
      chk("mosi_pulse_returns", {7'd0, mosi_cond}, 8'd0);

      // Gating: deselect, then toggle SCK -> level follows, no strobes
      cs_pin = 1'b1;
      expect_strobe(4'b0001, 3'b010);
      tick(10);
      for (int p = 0; p < 4; p++) begin
         sck_pin = 1'b1;
         tick(8);
         chk("gated_sck_high", {7'd0, sck_cond}, 8'd1);
         sck_pin = 1'b0;
         tick(8);
         chk("gated_sck_low", {7'd0, sck_cond}, 8'd0);
      end

      // Selected: 8 SCK pulses -> 8 rise and 8 fall strobes
      cs_pin = 1'b0;
      expect_strobe(4'b0010, 3'b000);
      tick(10);
      for (int p = 0; p < 8; p++) begin
         sck_pin = 1'b1;
         expect_strobe(4'b1000, 3'b100);
         tick(8);
         sck_pin = 1'b0;
         expect_strobe(4'b0100, 3'b000);
         tick(8);
      end

      // Coincident edges
      cs_pin = 1'b1;
      expect_strobe(4'b0001, 3'b010);
      tick(10);
      cs_pin  = 1'b0;
      sck_pin = 1'b1;
      expect_strobe(4'b1010, 3'b100);   // cs_fall + sck_rise together
      tick(10);
      cs_pin  = 1'b1;
      sck_pin = 1'b0;
      expect_strobe(4'b0001, 3'b010);   // cs_rise only, sck_fall suppressed
      tick(10);

      // Full byte 0xA5, MSB first, MOSI changed with SCK falling
      cs_pin = 1'b0;
      expect_strobe(4'b0010, 3'b000);
      tick(10);
      mosi_pin = byte_val[7];
      tick(8);
      for (int b = 7; b >= 0; b--) begin
         sck_pin = 1'b1;
         expect_strobe(4'b1000, {1'b1, 1'b0, byte_val[b]});
         tick(8);
         sck_pin  = 1'b0;
         mosi_pin = (b > 0) ? byte_val[b-1] : 1'b0;
         expect_strobe(4'b0100, {1'b0, 1'b0, mosi_pin});
         tick(8);
      end
      cs_pin = 1'b1;
      expect_strobe(4'b0001, 3'b010);
      tick(10);

      // Reset mid-debounce with conditioned levels away from reset values
      cs_pin = 1'b0;
      expect_strobe(4'b0010, 3'b000);
      tick(10);
      mosi_pin = 1'b1;
      tick(10);
      chk("pre_reset_mosi", {7'd0, mosi_cond}, 8'd1);
      sck_pin = 1'b1;
      tick(2);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_outs", all_outs(), 8'b0010_0000);
      tick(3);
      chk("held_reset_outs", all_outs(), 8'b0010_0000);
      rst_n = 1'b1;
      expect_strobe(4'b1010, 3'b101);    // re-evaluated from reset values
      tick(10);

      // Close out: cs_rise with coincident SCK fall and MOSI low
      cs_pin   = 1'b1;
      sck_pin  = 1'b0;
      mosi_pin = 1'b0;
      expect_strobe(4'b0001, 3'b010);
      tick(12);
      chk("exp_q_drained", 8'(exp_q.size()), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/spi_input_conditioner.md
# spi_input_conditioner

Front-end conditioner for the SPI slave: takes raw, asynchronous `sck`, `cs` and `mosi` pins, synchronizes each into the `clk` domain, debounces it and produces clean levels plus single-cycle edge strobes. It sits directly upstream of the SPI finite state machine and the input shift register; they consume its conditioned levels and strobes instead of sampling pins or tracking a previous `sck` value themselves.

## Interface
Parameters:
- `WAIT_CYCLES`, 3: consecutive cycles a synchronized input must differ from its conditioned value before the change is accepted; legal range 1..2^`COUNTER_WIDTH`.
- `COUNTER_WIDTH`, 3: width of each per-channel debounce counter.

Ports:
- `clk` input 1: system clock; all state updates on rising edge.
- `rst_n` input 1: one clock; reset is asynchronous and active-low.
- `sck_pin` input 1: raw SPI clock pin.
- `cs_pin` input 1: raw chip select pin, active low.
- `mosi_pin` input 1: raw master-out data pin.
- `sck_cond` output 1: conditioned SCK level.
- `cs_cond` output 1: conditioned CS level (1 = deselected).
- `mosi_cond` output 1: conditioned MOSI level.
- `sck_rise` output 1: one-cycle strobe, accepted SCK 0→1 while selected.
- `sck_fall` output 1: one-cycle strobe, accepted SCK 1→0 while selected.
- `cs_fall` output 1: one-cycle strobe, frame start (accepted CS 1→0).
- `cs_rise` output 1: one-cycle strobe, frame end (accepted CS 0→1).

## Operation
- Three identical, independent channels (sck, cs, mosi), each: two-flop synchronizer `s0 <= pin; s1 <= s0`, then debounce counter `cnt`, then conditioned register `cond`.
- Per channel, each rising `clk`:
  - `s1 == cond`: `cnt <= 0`, no change.
  - `s1 != cond` and `cnt == WAIT_CYCLES-1`: `cond <= s1`, `cnt <= 0`, raise the matching rise/fall strobe for one cycle.
  - otherwise: `cnt <= cnt + 1`.
- Glitch at `s1` lasting fewer than `WAIT_CYCLES` cycles is rejected: counter clears as soon as `s1` returns to `cond`; no strobe.
- Counter never exceeds `WAIT_CYCLES-1`; no wrap possible.
- `sck_rise`/`sck_fall` gated by `cs_cond` as updated on the same edge: suppressed while `cs_cond` = 1. `sck_cond` itself is never gated.
- `cs_fall`/`cs_rise` ungated.
- Strobes are registered outputs, not combinational decodes of `cond`.
- Simultaneous events: channels update independently in the same cycle; `cs_fall` and `sck_rise` may assert together (sck strobe passes since `cs_cond` is 0 after that edge); `cs_rise` coincident with an SCK edge suppresses that SCK strobe.

Reset (`rst_n` low, takes effect immediately, no clock needed):
- `cs` channel: `s0`, `s1`, `cs_cond` = 1.
- `sck`, `mosi` channels: `s0`, `s1`, `cond` = 0.
- All counters 0; all strobes 0.
- Reset mid-debounce discards the pending change; after release the channel re-evaluates from reset values (a pin held low on CS yields `cs_fall` after normal latency).

## Timing
- Pin change stable before edge 1: `s0` at edge 1, `s1` at edge 2, `cond` and strobe update at edge 2+`WAIT_CYCLES` (edge 5 for default).
- Strobe high exactly one cycle, aligned with the first cycle of the new `cond` value.
- Minimum accepted pulse width: `WAIT_CYCLES` clk cycles at `s1`; thus SCK half-period must exceed `WAIT_CYCLES` cycles plus synchronizer uncertainty (1 cycle).
- `mosi_cond` and `sck_cond` have identical latency, so MOSI setup relative to SCK at the pins is preserved at `sck_rise`.
- No back-pressure; outputs valid every cycle after reset release.

## Test plan
- Reset: assert `rst_n`=0 mid-simulation with pins toggling -> instantly `cs_cond`=1, `sck_cond`=`mosi_cond`=0, all strobes 0, counters 0.
- Latency (WAIT_CYCLES=3): `cs_pin` 1→0 just before edge 1, held -> `cs_cond`=0 and `cs_fall`=1 after edge 5, `cs_fall`=0 after edge 6.
- Glitch rejection: `mosi_pin` 0→1 for 2 cycles then back to 0 -> `mosi_cond` stays 0, `cnt` returns to 0; 3-cycle-stable pulse (at `s1`) -> `mosi_cond` goes 1.
- Gating: toggle `sck_pin` with 8-cycle half-period while `cs_pin`=1 -> `sck_cond` follows, `sck_rise`/`sck_fall` never assert; repeat with `cs_pin`=0 -> 8 rising strobes for 8 SCK pulses, one cycle each.
- Coincident edges: drive `cs_pin` 1→0 and `sck_pin` 0→1 on same cycle -> `cs_fall` and `sck_rise` assert on same cycle; `cs_pin` 0→1 with `sck_pin` 1→0 -> `cs_rise` only, no `sck_fall`.
- Full byte: CS low, 8 SCK cycles, MOSI pattern 0xA5 changed on SCK falling -> `mosi_cond` sampled at each `sck_rise` reads 1,0,1,0,0,1,0,1; `cs_rise` after CS release.
